// File: rtl/serv_mdu_iter_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encoding and iteration/latency counts.
package serv_mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int ITER    = 32;
  localparam int LATENCY = 34;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/serv_mdu_iter_if.sv
// Extension-port bundle between the core (master) and the MDU (slave).
interface serv_mdu_iter_if;

  // i_valid is a level request; an operation starts on its rising edge and
  // operands are sampled only in that cycle. o_ready pulses for exactly one
  // cycle when o_rd carries the result; there is no back-pressure.
  logic        i_valid;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [2:0]  i_funct3;
  logic [31:0] o_rd;
  logic        o_ready;

  modport master (output i_valid, i_rs1, i_rs2, i_funct3, input o_rd, o_ready);
  modport slave  (input i_valid, i_rs1, i_rs2, i_funct3, output o_rd, o_ready);

endinterface

// File: rtl/serv_mdu_negate.sv
// 32-bit conditional two's-complement negation.
module serv_mdu_negate (
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  assign dout = en ? (~din + 32'd1) : din;

endmodule

// File: rtl/serv_mdu_iter.sv
// Iterative RV32M multiply/divide: magnitude shift-add / restoring division,
// one radix-2 step per cycle, sign fix-up at the end, fixed 34-cycle latency.
module serv_mdu_iter
  import serv_mdu_pkg::*;
#(
  parameter string RESET_STRATEGY = "MINI"
) (
  input  logic             clk,
  input  logic             i_rst,
  serv_mdu_iter_if.slave   bus,
  output mdu_state_e       dbg_state
);

  localparam logic [4:0] LAST = 5'(ITER - 1);

  mdu_state_e  state_q, state_d;
  logic        valid_q;
  logic        ready_q, ready_d;
  logic [31:0] rd_q, rd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  f3_q, f3_d;
  logic        sign_q, sign_d;

  logic        start, signed_a, signed_b, s_a, s_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_diff;
  logic [63:0] div_sh;
  logic        is_high, lo_zero, fix_neg_en;
  logic [31:0] fix_sel, fix_neg, fix_res;

  assign start    = (state_q == S_IDLE) && bus.i_valid && !valid_q;
  assign signed_a = (bus.i_funct3 == F3_MULH) || (bus.i_funct3 == F3_MULHSU) ||
                    (bus.i_funct3 == F3_DIV)  || (bus.i_funct3 == F3_REM);
  assign signed_b = (bus.i_funct3 == F3_MULH) || (bus.i_funct3 == F3_DIV) ||
                    (bus.i_funct3 == F3_REM);
  assign s_a      = signed_a && bus.i_rs1[31];
  assign s_b      = signed_b && bus.i_rs2[31];

  serv_mdu_negate u_neg_a (.en(s_a), .din(bus.i_rs1), .dout(mag_a));
  serv_mdu_negate u_neg_b (.en(s_b), .din(bus.i_rs2), .dout(mag_b));

  // acc_q holds {acc, mplier} while multiplying and {rem, quot} while dividing
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
  assign div_sh   = {acc_q[62:0], 1'b0};
  assign div_diff = {acc_q[63], div_sh[63:32]} - {1'b0, opb_q};

  // Negating a 64-bit product: the high word takes the +1 carry only when the low word is zero
  assign is_high    = !f3_q[2] && (f3_q != F3_MUL);
  assign lo_zero    = (acc_q[31:0] == 32'd0);
  assign fix_sel    = f3_q[2] ? (f3_q[1] ? acc_q[63:32] : acc_q[31:0])
                              : (is_high ? acc_q[63:32] : acc_q[31:0]);
  assign fix_neg_en = sign_q && (!is_high || lo_zero);

  serv_mdu_negate u_neg_res (.en(fix_neg_en), .din(fix_sel), .dout(fix_neg));

  assign fix_res = (is_high && sign_q && !lo_zero) ? ~acc_q[63:32] : fix_neg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    sign_d  = sign_q;
    ready_d = 1'b0;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = bus.i_funct3;
          cnt_d = 5'd0;
          if (!bus.i_funct3[2])
            sign_d = s_a ^ s_b;
          else if (bus.i_funct3[1])
            sign_d = s_a;
          else
            sign_d = (s_a ^ s_b) && (bus.i_rs2 != 32'd0);
          if (bus.i_funct3[2]) begin
            acc_d   = {32'd0, mag_a};
            opb_d   = mag_b;
            state_d = S_DIV;
          end else begin
            acc_d   = {32'd0, mag_b};
            opb_d   = mag_a;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_diff[32])
          acc_d = {div_diff[31:0], div_sh[31:1], 1'b1};
        else
          acc_d = div_sh;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        rd_d    = fix_res;
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= bus.i_valid;
      ready_q <= ready_d;
    end
  end

  generate
    if (RESET_STRATEGY == "NONE") begin : g_dp_noreset
      always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        acc_q  <= acc_d;
        opb_q  <= opb_d;
        f3_q   <= f3_d;
        sign_q <= sign_d;
        rd_q   <= rd_d;
      end
    end else begin : g_dp_reset
      always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
          cnt_q  <= 5'd0;
          acc_q  <= 64'd0;
          opb_q  <= 32'd0;
          f3_q   <= 3'd0;
          sign_q <= 1'b0;
          rd_q   <= 32'd0;
        end else begin
          cnt_q  <= cnt_d;
          acc_q  <= acc_d;
          opb_q  <= opb_d;
          f3_q   <= f3_d;
          sign_q <= sign_d;
          rd_q   <= rd_d;
        end
      end
    end
  endgenerate

  assign bus.o_ready = ready_q;
  assign bus.o_rd    = rd_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_serv_mdu_iter.sv
// Directed-vector bench for serv_mdu_iter: latency, pulse shape, results,
// divide-by-zero/overflow corners, level-hold and mid-operation reset.
module tb_serv_mdu_iter;
  import serv_mdu_pkg::*;

  logic       clk;
  logic       i_rst;
  mdu_state_e dbg_state;
  int         pass_cnt;
  int         total_cnt;

  serv_mdu_iter_if bus ();

  serv_mdu_iter #(.RESET_STRATEGY("MINI")) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation on a fresh i_valid edge, scrambles operands after
  // capture, and checks latency, pulse width and result.
  task automatic run_op(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    logic early;
    early = 1'b0;
    @(negedge clk);
    bus.i_funct3 = f3;
    bus.i_rs1    = a;
    bus.i_rs2    = b;
    bus.i_valid  = 1'b1;
    for (int k = 1; k <= LATENCY; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        bus.i_rs1    = $urandom;
        bus.i_rs2    = $urandom;
        bus.i_funct3 = 3'($urandom_range(0, 7));
      end
      if (k < LATENCY && bus.o_ready === 1'b1) early = 1'b1;
    end
    total_cnt++;
    if (early !== 1'b0) $display("FAIL %s early_ready: saw ready=1 before cycle %0d, required 0", name, LATENCY);
    else pass_cnt++;
    total_cnt++;
    if (bus.o_ready !== 1'b1) $display("FAIL %s ready_latency: ready=%b at cycle %0d, required 1", name, bus.o_ready, LATENCY);
    else pass_cnt++;
    total_cnt++;
    if (bus.o_rd !== exp) $display("FAIL %s result: rd=%h, required %h", name, bus.o_rd, exp);
    else pass_cnt++;
    bus.i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.o_ready !== 1'b0 || bus.o_rd !== exp)
      $display("FAIL %s pulse_hold: ready=%b rd=%h, required ready=0 rd=%h", name, bus.o_ready, bus.o_rd, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.i_valid  = 1'b0;
    bus.i_rs1    = 32'd0;
    bus.i_rs2    = 32'd0;
    bus.i_funct3 = 3'd0;
    i_rst        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (dbg_state !== S_IDLE || bus.o_ready !== 1'b0 || bus.o_rd !== 32'd0)
      $display("FAIL reset_state: state=%0d ready=%b rd=%h, required state=0 ready=0 rd=00000000",
               dbg_state, bus.o_ready, bus.o_rd);
    else pass_cnt++;
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op("mul_7_m3",      F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    run_op("mul_m1_m1",     F3_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_op("mulh_min_min",  F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mulhu_max",     F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulhsu_m1_max", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulh_lo_zero",  F3_MULH,   32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF);
  endtask

  task automatic test_div();
    run_op("div_m7_2",  F3_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_op("rem_m7_2",  F3_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_op("divu_100_7", F3_DIVU, 32'd100,     32'd7, 32'd14);
    run_op("remu_100_7", F3_REMU, 32'd100,     32'd7, 32'd2);
  endtask

  task automatic test_div_corners();
    run_op("div_5_0",    F3_DIV,  32'd5,        32'd0,        32'hFFFFFFFF);
    run_op("divu_5_0",   F3_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF);
    run_op("div_m5_0",   F3_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF);
    run_op("rem_m5_0",   F3_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    run_op("remu_5_0",   F3_REMU, 32'd5,        32'd0,        32'd5);
    run_op("div_ovf",    F3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf",    F3_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000);
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first_at;
    pulses   = 0;
    first_at = -1;
    @(negedge clk);
    bus.i_funct3 = F3_DIVU;
    bus.i_rs1    = 32'd100;
    bus.i_rs2    = 32'd7;
    bus.i_valid  = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.o_ready === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
    total_cnt++;
    if (pulses != 1 || first_at != LATENCY)
      $display("FAIL hold_level: pulses=%0d first_at=%0d, required pulses=1 first_at=%0d", pulses, first_at, LATENCY);
    else pass_cnt++;
    total_cnt++;
    if (bus.o_rd !== 32'd14) $display("FAIL hold_level_rd: rd=%h, required %h", bus.o_rd, 32'd14);
    else pass_cnt++;
    bus.i_valid = 1'b0;
    run_op("retrigger_mul", F3_MUL, 32'd1000, 32'd1000, 32'd1000000);
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.i_funct3 = F3_DIV;
    bus.i_rs1    = 32'd12345;
    bus.i_rs2    = 32'd7;
    bus.i_valid  = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    i_rst       = 1'b1;
    #1;
    total_cnt++;
    if (dbg_state !== S_IDLE || bus.o_ready !== 1'b0)
      $display("FAIL reset_mid_state: state=%0d ready=%b, required state=0 ready=0", dbg_state, bus.o_ready);
    else pass_cnt++;
    @(negedge clk);
    i_rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.o_ready === 1'b1) pulses++;
    end
    total_cnt++;
    if (pulses != 0 || dbg_state !== S_IDLE)
      $display("FAIL reset_mid_no_pulse: pulses=%0d state=%0d, required pulses=0 state=0", pulses, dbg_state);
    else pass_cnt++;
    run_op("after_reset_div", F3_DIV, 32'd12345, 32'd7, 32'd1763);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_corners();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serv_mdu_iter.md
Name: serv_mdu_iter

Overview:
- Iterative RV32M multiply/divide unit on the core's extension port, directly downstream of the RF-top.
- Consumes o_ext_rs1/o_ext_rs2/o_ext_funct3 qualified by o_mdu_valid.
- Returns the result on i_ext_rd with a one-cycle i_ext_ready pulse.
- One radix-2 step per cycle; fixed latency for every operation.

Parameters:
RESET_STRATEGY, "MINI", "MINI": control and datapath registers reset; "NONE": only the FSM state, o_ready and the edge-detect flop are reset.

Ports:
clk  input  1  clock
i_rst  input  1  asynchronous active-high reset
i_valid  input  1  request, level; connects to o_mdu_valid
i_rs1  input  32  operand A (multiplicand / dividend)
i_rs2  input  32  operand B (multiplier / divisor)
i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
o_rd  output  32  result; valid only while o_ready=1
o_ready  output  1  one-cycle completion pulse; connects to i_ext_ready

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, o_ready=0, valid_q=0.
  - o_rd=0 under "MINI"; undefined under "NONE".
- Start: in IDLE, a request starts when i_valid=1 and valid_q=0 (rising edge).
  - valid_q is i_valid registered every cycle.
  - A level held across completion never retriggers; a new operation needs i_valid low for at least one cycle.
- Capture cycle (start edge):
  - Latch funct3.
  - Latch |A| and |B| as 32-bit magnitudes. An operand is treated as signed for MULH (A,B), MULHSU (A only), DIV/REM (A,B).
  - Latch the result sign flag: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- MUL, 32 cycles (5-bit counter 0..31):
  - Shift-add on a 64-bit {acc,mplier} register.
  - Each cycle: if lsb, add multiplicand into acc[63:32] with a 33-bit sum; then shift right by 1.
- DIV, 32 cycles:
  - Restoring division on {rem[31:0],quot[31:0]}.
  - Each cycle: shift left by 1, trial-subtract the divisor with a 33-bit subtract, keep it if non-negative, set the quot lsb.
- FIX, 1 cycle: apply two's-complement negation when the sign flag is set, then select the output:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE, 1 cycle: o_ready=1, o_rd=result; next state IDLE.
  - o_ready=0 in all other states.
  - o_rd is registered and holds its value after DONE.
- Latency: start edge in cycle T → o_ready high in cycle T+34, independent of operand values.
- Divide by zero (B=0):
  - quotient=0xFFFFFFFF for DIV and DIVU; quotient sign correction is suppressed.
  - remainder=A (original signed value) for REM and REMU.
- Overflow (DIV, A=0x80000000, B=0xFFFFFFFF): quotient=0x80000000, remainder=0. The magnitude datapath produces this naturally; no special case is needed.
- Operand magnitude of 0x80000000 is 2^31 and is handled as unsigned 32-bit.
- i_valid deasserting mid-operation is ignored; the operation completes and pulses o_ready.
- i_rs1/i_rs2/i_funct3 changes after the capture cycle have no effect.
- Reset mid-operation: immediate return to IDLE; no o_ready pulse.

Decomposition:
- Package serv_mdu_pkg holds:
  - the funct3 opcode constants;
  - the FSM state encoding (IDLE, MUL, DIV, FIX, DONE);
  - ITER=32 and LATENCY=34.
- One natural sub-module: serv_mdu_negate, a 32-bit conditional two's-complement. It is used for operand magnitude and for result fix-up.
- The remainder of the block is a single module.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) → o_rd=0xFFFFFFEB. o_ready at exactly T+34 as a single-cycle pulse.
- MULH A=0x80000000, B=0x80000000 → 0x40000000. MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE. MULHSU A=-1, B=0xFFFFFFFF → 0xFFFFFFFF.
- DIV A=-7, B=2 → 0xFFFFFFFD (-3). REM A=-7, B=2 → 0xFFFFFFFF (-1). DIVU A=100, B=7 → 14. REMU A=100, B=7 → 2.
- B=0: DIV/DIVU A=5 → 0xFFFFFFFF; REM A=-5 → 0xFFFFFFFB. Overflow DIV 0x80000000/-1 → 0x80000000; REM of the same operands → 0.
- Hold i_valid high for 80 cycles after start → exactly one o_ready pulse. Drop i_valid one cycle, raise it again → second result 34 cycles after the new edge.
- Assert i_rst at iteration 10 → o_ready never pulses, state returns to IDLE. A new request after reset release completes correctly with latency 34.
